// File: rtl/debounce_sync.sv
// debounce_sync: N-stage synchronizer followed by a counter-based debounce FSM.
// Turns a raw, bouncing asynchronous input into a clean registered level.
// Optional feature macro: DEBOUNCE_EDGE_EN adds registered one-cycle rise/fall strobes
// that line up with the cycle in which dout takes its new value.
module debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } state_e;

  logic [SYNC_STAGES-1:0] syncChain_q;
  logic                   syncOut;
  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   dout_q, dout_d;

  assign syncOut = syncChain_q[SYNC_STAGES-1];

  // Plain flop chain for metastability settling; din gets no logic before the first stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      syncChain_q <= '0;
    end else begin
      syncChain_q <= {syncChain_q[SYNC_STAGES-2:0], din};
    end
  end

  // Debounce state, qualification counter and filtered level registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= STABLE_LO;
      count_q <= '0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

  // Next-state logic: a level must be seen DEBOUNCE_CYCLES times in a row to commit;
  // any opposite sample during qualification drops back to the current stable state.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dout_d  = dout_q;
    case (state_q)
      STABLE_LO: begin
        count_d = '0;
        if (syncOut) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = STABLE_HI;
            dout_d  = 1'b1;
          end else begin
            state_d = WAIT_HI;
            count_d = CNT_ONE;
          end
        end
      end
      WAIT_HI: begin
        if (!syncOut) begin
          state_d = STABLE_LO;
          count_d = '0;
        end else if (count_q == CNT_LAST) begin
          state_d = STABLE_HI;
          dout_d  = 1'b1;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        count_d = '0;
        if (!syncOut) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = STABLE_LO;
            dout_d  = 1'b0;
          end else begin
            state_d = WAIT_LO;
            count_d = CNT_ONE;
          end
        end
      end
      WAIT_LO: begin
        if (syncOut) begin
          state_d = STABLE_HI;
          count_d = '0;
        end else if (count_q == CNT_LAST) begin
          state_d = STABLE_LO;
          dout_d  = 1'b0;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        count_d = '0;
        dout_d  = 1'b0;
      end
    endcase
  end

  assign dout = dout_q;

`ifdef DEBOUNCE_EDGE_EN
  logic risePulse_q, fallPulse_q;

  // Strobes are derived from the commit itself so they coincide with the new dout value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      risePulse_q <= 1'b0;
      fallPulse_q <= 1'b0;
    end else begin
      risePulse_q <= dout_d & ~dout_q;
      fallPulse_q <= ~dout_d & dout_q;
    end
  end

  assign rise_pulse = risePulse_q;
  assign fall_pulse = fallPulse_q;
`else
  assign rise_pulse = 1'b0;
  assign fall_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Testbench for debounce_sync with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Inputs change on the falling edge (mid-cycle); outputs are sampled 1 ns after each rising edge.
// Expected pulse values are forced to 0 unless DEBOUNCE_EDGE_EN is defined.
module tb_debounce_sync;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  typedef struct {
    logic rstN;
    logic din;
    logic dout;
    logic rise;
    logic fall;
  } vec_t;

  typedef struct {
    logic dout;
    logic rise;
    logic fall;
  } exp_t;

  logic clk;
  logic reset_n;
  logic din;
  logic dout;
  logic rise_pulse;
  logic fall_pulse;

  vec_t vecs[$];
  exp_t expQ[$];
  int   vectorCount = 0;
  int   missCount   = 0;

  debounce_sync #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .din       (din),
    .dout      (dout),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void addRun(input logic rstN, input logic dinV, input logic doutV, input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.rstN = rstN; v.din = dinV; v.dout = doutV; v.rise = 1'b0; v.fall = 1'b0;
      vecs.push_back(v);
    end
  endfunction

  function automatic void addEdge(input logic dinV, input logic doutV, input logic riseV, input logic fallV);
    vec_t v;
    v.rstN = 1'b1; v.din = dinV; v.dout = doutV; v.rise = riseV; v.fall = fallV;
    vecs.push_back(v);
  endfunction

  function automatic void pushExpected(input logic doutV, input logic riseV, input logic fallV);
    exp_t e;
    e.dout = doutV;
    e.rise = EDGE_EN ? riseV : 1'b0;
    e.fall = EDGE_EN ? fallV : 1'b0;
    expQ.push_back(e);
  endfunction

  task automatic checkOutput(input string tag);
    exp_t e;
    vectorCount++;
    if (expQ.size() == 0) begin
      missCount++;
      $display("[TB] FAIL %s: scoreboard empty, got dout=%b rise=%b fall=%b", tag, dout, rise_pulse, fall_pulse);
    end else begin
      e = expQ.pop_front();
      if (dout !== e.dout || rise_pulse !== e.rise || fall_pulse !== e.fall) begin
        missCount++;
        $display("[TB] FAIL %s @%0t: got dout=%b rise=%b fall=%b, expected dout=%b rise=%b fall=%b",
                 tag, $time, dout, rise_pulse, fall_pulse, e.dout, e.rise, e.fall);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    reset_n = v.rstN;
    din     = v.din;
    pushExpected(v.dout, v.rise, v.fall);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic asyncResetNow(input string tag);
    reset_n = 1'b0;
    pushExpected(1'b0, 1'b0, 1'b0);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    vec_t v;
    reset_n = 1'b0;
    din     = 1'b1;

    // Reset held with din high, then release with din low.
    addRun(1'b0, 1'b1, 1'b0, 3);
    addRun(1'b1, 1'b0, 1'b0, 2);
    // Clean rise: commit on edge 6.
    addRun(1'b1, 1'b1, 1'b0, 5);
    addEdge(1'b1, 1'b1, 1'b1, 1'b0);
    addRun(1'b1, 1'b1, 1'b1, 2);
    // Clean fall: commit on edge 6.
    addRun(1'b1, 1'b0, 1'b1, 5);
    addEdge(1'b0, 1'b0, 1'b0, 1'b1);
    addRun(1'b1, 1'b0, 1'b0, 2);
    // Glitch: two high cycles are rejected.
    addRun(1'b1, 1'b1, 1'b0, 2);
    addRun(1'b1, 1'b0, 1'b0, 6);
    // Bounce: toggle for 10 cycles, then settle high; commit 6 edges after settling.
    for (int i = 0; i < 10; i++) addRun(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 1);
    addRun(1'b1, 1'b1, 1'b0, 5);
    addEdge(1'b1, 1'b1, 1'b1, 1'b0);
    addRun(1'b1, 1'b1, 1'b1, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset while dout is high must clear it without a clock edge.
    asyncResetNow("asyncResetHigh");

    // Reset mid-WAIT_HI: qualification is discarded and full latency restarts.
    v.rise = 1'b0; v.fall = 1'b0; v.dout = 1'b0;
    v.rstN = 1'b0; v.din = 1'b0;
    applyStimulus(v, "holdReset");
    v.rstN = 1'b1;
    for (int i = 0; i < 2; i++) applyStimulus(v, "releaseLow");
    v.din = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(v, $sformatf("waitHiEdge%0d", i + 1));
    asyncResetNow("resetInWaitHi");
    v.rstN = 1'b0;
    applyStimulus(v, "resetInWaitHiHold");
    v.rstN = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(v, $sformatf("postReleaseEdge%0d", i + 1));
    v.dout = 1'b1; v.rise = 1'b1;
    applyStimulus(v, "postReleaseCommit");
    v.rise = 1'b0;
    applyStimulus(v, "postReleaseHold");

    if (expQ.size() != 0) begin
      missCount++;
      $display("[TB] FAIL leftover: got %0d pending entries, expected 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
